lcd_bus_driver: RTL and testbench

- Downstream executor for the character-LCD init/display sequencer. It accepts one 10-bit LCD instruction word {RS, RW, DB[7:0]} per handshake and drives the HD44780-style parallel bus with correct setup, enable-pulse and hold timing.
- After each instruction it waits the controller's execution time before accepting the next, so upstream FSMs issue instruction words and never touch bus timing.
- Instructions with RW=1 (busy-flag or data reads) return the sampled bus byte.

---
 rtl/lcd_bus_driver.sv | 184 ++++++++++++++++++
 tb/tb_lcd_bus_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_driver.sv
// HD44780-style parallel bus executor: takes one {RS, RW, DB} instruction per handshake,
// sequences setup / enable / hold timing, then waits out the controller execution time.
module lcd_bus_driver #(
   parameter int T_SETUP     = 8,
   parameter int T_EN        = 25,
   parameter int T_HOLD      = 4,
   parameter int T_EXEC      = 2000,
   parameter int T_EXEC_LONG = 80000,
   parameter int CNT_W       = 17
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [9:0] i_cmd,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_done,
   output logic [7:0] o_rdata,
   output logic       o_rvalid,
   inout  wire  [7:0] io_LCD_DATA,
   output logic       o_LCD_EN,
   output logic       o_LCD_RS,
   output logic       o_LCD_RW,
   output logic       o_LCD_ON,
   output logic       o_LCD_BLON
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_EN    = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_EXEC  = 3'd4;

   localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] C_EN    = CNT_W'(T_EN - 1);
   localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] C_EXEC  = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(T_EXEC_LONG - 1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [9:0]       cmd_q, cmd_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             rvalid_q, rvalid_d;
   logic             en_q, en_d;
   logic             rs_q, rs_d;
   logic             rw_q, rw_d;
   logic [7:0]       db_q, db_d;
   logic             drive_q, drive_d;
   logic             on_q, on_d;

   logic accept;
   logic cnt_zero;
   logic is_read;
   logic is_long;
   logic bus_phase;
   logic sample;

   assign accept   = i_valid & ready_q;
   assign cnt_zero = (cnt_q == '0);
   assign is_read  = cmd_q[8];
   // Clear Display (0x01) and Return Home (0x02/0x03) need the long execution wait.
   assign is_long  = (cmd_q[9:8] == 2'b00) && (cmd_q[7:2] == 6'd0) && (cmd_q[1:0] != 2'b00);

   // NOTE: every output of this block defaults to its previous value first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cmd_d   = i_cmd;
               state_d = S_SETUP;
               cnt_d   = C_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt_zero) begin
               state_d = S_EN;
               cnt_d   = C_EN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_EN: begin
            if (cnt_zero) begin
               state_d = S_HOLD;
               cnt_d   = C_HOLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (cnt_zero) begin
               if (is_read) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d = S_EXEC;
                  cnt_d   = is_long ? C_LONG : C_EXEC;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_EXEC: begin
            if (cnt_zero) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Pins are registered from the current state, so they trail the state register by one edge.
   always_comb begin
      bus_phase = (state_q == S_SETUP) || (state_q == S_EN) || (state_q == S_HOLD);
      ready_d   = (state_q == S_IDLE) && !accept;
      done_d    = (state_q == S_IDLE) && !ready_q;
      en_d      = (state_q == S_EN);
      rs_d      = bus_phase ? cmd_q[9] : rs_q;
      rw_d      = bus_phase ? cmd_q[8] : rw_q;
      drive_d   = bus_phase && !cmd_q[8];
      db_d      = bus_phase ? cmd_q[7:0] : db_q;
      // Capture the read byte on the edge that drops EN, while the panel still drives it.
      sample    = (state_q == S_HOLD) && en_q && is_read;
      rdata_d   = sample ? io_LCD_DATA : rdata_q;
      rvalid_d  = sample;
      on_d      = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only; every flop, cmd_q included, resets asynchronously.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         cmd_q    <= '0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         en_q     <= 1'b0;
         rs_q     <= 1'b0;
         rw_q     <= 1'b0;
         db_q     <= '0;
         drive_q  <= 1'b0;
         on_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         en_q     <= en_d;
         rs_q     <= rs_d;
         rw_q     <= rw_d;
         db_q     <= db_d;
         drive_q  <= drive_d;
         on_q     <= on_d;
      end
   end

   assign io_LCD_DATA = drive_q ? db_q : 8'hzz;
   assign o_ready     = ready_q;
   assign o_done      = done_q;
   assign o_rdata     = rdata_q;
   assign o_rvalid    = rvalid_q;
   assign o_LCD_EN    = en_q;
   assign o_LCD_RS    = rs_q;
   assign o_LCD_RW    = rw_q;
   assign o_LCD_ON    = on_q;
   assign o_LCD_BLON  = on_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench for lcd_bus_driver: stimulus pushes accepted commands, a negedge monitor
// checks pins, read data and completion timing against cycle offsets derived from the timing rules.
module tb_lcd_bus_driver;

   localparam int TS = 2;
   localparam int TEN = 3;
   localparam int TH = 1;
   localparam int TE = 5;
   localparam int TL = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] cmd;
   logic       valid;
   logic       ready, done, rvalid;
   logic [7:0] rdata;
   logic       lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon;
   logic [7:0] rd_byte;
   tri1  [7:0] lcd_data;

   // Panel model: drives the bus only while a read strobe is active; undriven bus pulls to 0xFF.
   assign lcd_data = (lcd_rw && lcd_en) ? rd_byte : 8'hzz;

   lcd_bus_driver #(
      .T_SETUP(TS), .T_EN(TEN), .T_HOLD(TH), .T_EXEC(TE), .T_EXEC_LONG(TL), .CNT_W(17)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cmd(cmd), .i_valid(valid),
      .o_ready(ready), .o_done(done), .o_rdata(rdata), .o_rvalid(rvalid),
      .io_LCD_DATA(lcd_data), .o_LCD_EN(lcd_en), .o_LCD_RS(lcd_rs), .o_LCD_RW(lcd_rw),
      .o_LCD_ON(lcd_on), .o_LCD_BLON(lcd_blon)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [9:0] cmd;
      logic [7:0] rd;
      int         acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   bit   mon_on = 1'b0;
   bit   got_rv = 1'b0;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
      end
   endtask

   // Cycles from the accept edge to o_done, straight from the timing rules.
   function automatic int lat_of(input logic [9:0] c);
      int wait_n;
      if (c[8]) return TS + TEN + TH + 1;
      wait_n = (c[9] == 1'b0 && c[7:0] >= 8'd1 && c[7:0] <= 8'd3) ? TL : TE;
      return TS + TEN + TH + wait_n + 1;
   endfunction

   exp_t       m_e;
   int         m_rel, m_lat;
   logic       m_en;
   logic [7:0] m_bus;

   always @(negedge clk) begin
      if (rst_n && mon_on) begin
         if (sb.size() == 0) begin
            check(!lcd_en && lcd_data === 8'hFF && !done && !rvalid, "idle_quiet",
                  {21'd0, lcd_en, done, rvalid, lcd_data}, {21'd0, 3'b000, 8'hFF});
         end else begin
            m_e   = sb[0];
            m_rel = cyc - m_e.acc;
            m_lat = lat_of(m_e.cmd);
            if (m_rel >= 1) begin
               m_en = (m_rel >= TS + 1) && (m_rel <= TS + TEN);
               if (!m_e.cmd[8] && m_rel <= TS + TEN + TH) m_bus = m_e.cmd[7:0];
               else if (m_e.cmd[8] && m_en)                m_bus = m_e.rd;
               else                                       m_bus = 8'hFF;
               check(lcd_en === m_en && lcd_rs === m_e.cmd[9] && lcd_rw === m_e.cmd[8] && lcd_data === m_bus,
                     "bus_pins", {21'd0, lcd_en, lcd_rs, lcd_rw, lcd_data}, {21'd0, m_en, m_e.cmd[9], m_e.cmd[8], m_bus});
            end else begin
               check(!lcd_en && lcd_data === 8'hFF, "pins_before_setup",
                     {23'd0, lcd_en, lcd_data}, {23'd0, 1'b0, 8'hFF});
            end
            if (rvalid) begin
               got_rv = 1'b1;
               check(m_e.cmd[8] && rdata === m_e.rd && m_rel == TS + TEN + 1, "read_data",
                     {m_rel[15:0], 7'd0, m_e.cmd[8], rdata}, {16'(TS + TEN + 1), 8'd1, m_e.rd});
            end
            if (done) begin
               check(m_rel == m_lat, "done_cycle", m_rel, m_lat);
               if (m_e.cmd[8]) check(got_rv, "rvalid_seen", {31'd0, got_rv}, 32'd1);
               got_rv = 1'b0;
               void'(sb.pop_front());
            end else if (m_rel >= m_lat) begin
               check(1'b0, "done_missing", m_rel, m_lat);
               got_rv = 1'b0;
               void'(sb.pop_front());
            end
         end
      end
   end

   // Called on a negedge; returns on the negedge after the accept edge with i_valid still high.
   task automatic issue(input logic [9:0] c, input logic [7:0] rd, input bit b2b);
      int n;
      cmd   = c;
      valid = 1'b1;
      n = 0;
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         check(1'b0, "accept_timeout", n, 200);
         valid = 1'b0;
         return;
      end
      if (b2b) check(done === 1'b1, "b2b_accept_in_done", {31'd0, done}, 32'd1);
      rd_byte = rd;
      sb.push_back('{c, rd, cyc + 1});
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      valid = 1'b0;
      cmd   = 10'($urandom);
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check(1'b0, "drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   function automatic logic [9:0] rand_cmd();
      if ($urandom_range(0, 3) == 0) return {8'd0, 2'($urandom_range(1, 3))};
      return 10'($urandom);
   endfunction

   initial begin
      int n;
      logic [9:0] c;
      bit b;
      rst_n   = 1'b0;
      valid   = 1'b0;
      cmd     = '0;
      rd_byte = '0;
      repeat (2) @(negedge clk);
      check(ready && !lcd_en && lcd_data === 8'hFF && !done && !rvalid && rdata == 8'h00 && !lcd_on && !lcd_blon
            && !lcd_rs && !lcd_rw, "reset_values",
            {16'd0, ready, lcd_en, done, rvalid, lcd_on, lcd_blon, lcd_rs, lcd_rw, lcd_data},
            {16'd0, 8'b1000_0000, 8'hFF});
      rst_n = 1'b1;
      @(negedge clk);
      check(lcd_on && lcd_blon && ready && !lcd_en && lcd_data === 8'hFF, "power_on",
            {20'd0, lcd_on, lcd_blon, ready, lcd_en, lcd_data}, {20'd0, 4'b1110, 8'hFF});
      mon_on = 1'b1;

      issue(10'h038, 8'h00, 1'b0); drain();
      issue(10'h001, 8'h00, 1'b0); drain();
      issue(10'h206, 8'h00, 1'b0); drain();
      issue(10'h100, 8'h80, 1'b0); drain();

      issue(10'h03C, 8'h00, 1'b0);
      issue(10'h101, 8'($urandom), 1'b1);
      issue(10'h002, 8'h00, 1'b1);
      drain();

      // Reset in the middle of an enable pulse drops the command.
      issue(10'h0C5, 8'h00, 1'b0);
      valid = 1'b0;
      n = 0;
      while (!lcd_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(lcd_en, "reach_en", {31'd0, lcd_en}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check(!lcd_en && lcd_data === 8'hFF && ready && !done, "async_reset",
            {21'd0, lcd_en, ready, done, lcd_data}, {21'd0, 3'b010, 8'hFF});
      sb.delete();
      got_rv = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check(!done && !lcd_en && ready && lcd_data === 8'hFF, "reset_hold_quiet",
               {21'd0, done, lcd_en, ready, lcd_data}, {21'd0, 3'b001, 8'hFF});
      end
      rst_n = 1'b1;
      @(negedge clk);
      check(lcd_on && lcd_blon, "power_on_again", {30'd0, lcd_on, lcd_blon}, 32'd3);
      issue(10'h0C5, 8'h00, 1'b0); drain();

      for (int i = 0; i < 24; i++) begin
         c = rand_cmd();
         b = (i > 0) && ($urandom_range(0, 1) == 1);
         if (!b) begin
            drain();
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         issue(c, 8'($urandom), b);
      end
      drain();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
